// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and controller state encoding.
// Both the timing generator and the pixel generator import this package.
package vga_pkg;

  localparam int CNT_W = 10;

  // 640x480 @ 60 Hz industry timing, 25 MHz pixel rate
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_SYNC_POL = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_e;

  // Total period of one axis (line or frame) in pixels or lines.
  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping position counter plus visible/sync window
// decode of the value the counter is about to take.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             active_nxt_o,
  output logic             sync_nxt_o
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d, nxt;
  logic             at_last;

  // Next position and window decode on the value visible after this step.
  always_comb begin
    at_last      = (cnt_q == LAST);
    cnt_d        = at_last ? '0 : cnt_q + ONE;
    nxt          = step_i ? cnt_d : cnt_q;
    wrap_o       = step_i & at_last;
    active_nxt_o = (nxt < ACT_END);
    sync_nxt_o   = (nxt >= SYNC_LO) && (nxt < SYNC_HI);
  end

  // Position register, advanced only when the axis is stepped.
  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (step_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: IDLE/RUN/DRAIN controller driving a
// horizontal and a vertical axis counter. All outputs are registered and
// move only on pixel-strobe clocks.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = VGA_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  vga_state_e state_q, state_d;
  logic       h_step, h_wrap, v_wrap, frame_wrap;
  logic       h_act_nxt, v_act_nxt, h_sync_nxt, v_sync_nxt;
  logic       hsync_q, vsync_q, active_q, line_start_q, frame_start_q;
  logic       hsync_d, vsync_d, active_d, line_start_d, frame_start_d;

  // Counters sit at (0,0) while idle; the vertical axis steps on line wrap.
  assign h_step     = pix_en && (state_q != ST_IDLE);
  assign frame_wrap = h_wrap & v_wrap;

  vga_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_i      (h_step),
    .cnt_o       (x),
    .wrap_o      (h_wrap),
    .active_nxt_o(h_act_nxt),
    .sync_nxt_o  (h_sync_nxt)
  );

  vga_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_i      (h_wrap),
    .cnt_o       (y),
    .wrap_o      (v_wrap),
    .active_nxt_o(v_act_nxt),
    .sync_nxt_o  (v_sync_nxt)
  );

  // Next state and next registered outputs, evaluated for a strobe edge.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d       = ST_RUN;
          line_start_d  = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) state_d = ST_DRAIN;
        line_start_d  = h_wrap;
        frame_start_d = frame_wrap;
      end
      ST_DRAIN: begin
        if (frame_wrap && !en) begin
          state_d = ST_IDLE;
        end else begin
          if (en) state_d = ST_RUN;
          line_start_d  = h_wrap;
          frame_start_d = frame_wrap;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE) && h_act_nxt && v_act_nxt;
    hsync_d  = ((state_d != ST_IDLE) && h_sync_nxt) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((state_d != ST_IDLE) && v_sync_nxt) ? SYNC_POL : ~SYNC_POL;
  end

  // State and output registers: update on strobes, pulses clear otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      state_q       <= state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (15 x 8, 120 strobes per
// frame). Stimulus pushes the expected outputs for every clock into a
// scoreboard queue; a monitor pops and compares after each rising edge.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n, pix_en, en;
  logic       hsync, vsync, active, line_start, frame_start;
  logic [9:0] x, y;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .active     (active),
    .x          (x),
    .y          (y),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs, vs, act, ls, fs;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Tallies of observed DUT behaviour, maintained by the monitor.
  int   strobe_cnt = 0, fs_cnt = 0, fs_last = 0, fs_gap = 0, vs_low = 0;
  int   hs_fall_x = -1, hs_rise_x = -1;
  logic prev_hs = 1'b1;

  // Reference model state: 0 idle, 1 run, 2 drain.
  int   m_st, m_x, m_y;
  logic e_hs, e_vs, e_act;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_x   = 0;
    m_y   = 0;
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    e_act = 1'b0;
  endtask

  // One clock: drive pix_en, push the expected post-edge outputs.
  task automatic tick(input bit pe);
    exp_t e;
    logic ls, fs, hw, fw;
    ls = 1'b0;
    fs = 1'b0;
    @(negedge clk);
    pix_en = pe;
    if (!rst_n) begin
      model_reset();
    end else if (pe) begin
      if (m_st == 0) begin
        if (en) begin
          m_st = 1;
          ls   = 1'b1;
          fs   = 1'b1;
        end
      end else begin
        hw = (m_x == HT - 1);
        fw = hw && (m_y == VT - 1);
        if (hw) begin
          m_x = 0;
          m_y = fw ? 0 : m_y + 1;
        end else begin
          m_x = m_x + 1;
        end
        if (m_st == 2 && fw && !en) begin
          m_st = 0;
        end else begin
          ls   = hw;
          fs   = fw;
          m_st = en ? 1 : 2;
        end
      end
      e_act = (m_st != 0) && (m_x < HA) && (m_y < VA);
      e_hs  = !((m_st != 0) && (m_x >= HA + HF) && (m_x < HA + HF + HS));
      e_vs  = !((m_st != 0) && (m_y >= VA + VF) && (m_y < VA + VF + VS));
    end
    e.pe  = pe && rst_n;
    e.x   = 10'(m_x);
    e.y   = 10'(m_y);
    e.hs  = e_hs;
    e.vs  = e_vs;
    e.act = e_act;
    e.ls  = ls;
    e.fs  = fs;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Pixel strobe every fourth clock.
  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
    end
  endtask

  // Monitor: compare every clock's outputs against the queued expectation.
  initial begin
    exp_t        e;
    logic [24:0] got, want;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e    = sb_q.pop_front();
        got  = {x, y, hsync, vsync, active, line_start, frame_start};
        want = {e.x, e.y, e.hs, e.vs, e.act, e.ls, e.fs};
        check("scoreboard {x,y,hs,vs,act,ls,fs}", 32'(got), 32'(want));
        if (e.pe) begin
          strobe_cnt++;
          if (frame_start) begin
            fs_cnt++;
            fs_gap  = strobe_cnt - fs_last;
            fs_last = strobe_cnt;
          end
          if (!vsync) vs_low++;
          if (prev_hs && !hsync) hs_fall_x = int'(x);
          if (!prev_hs && hsync) hs_rise_x = int'(x);
          prev_hs = hsync;
        end
      end
    end
  end

  initial begin
    int fs_before;
    logic [9:0] x_hold, y_hold;

    rst_n  = 1'b0;
    pix_en = 1'b0;
    en     = 1'b0;
    model_reset();

    // Reset values while pix_en is low and high.
    #12;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_active", 32'(active), 32'd0);
    check("rst_pulses", 32'({line_start, frame_start}), 32'd0);
    tick(1'b1);
    tick(1'b0);
    rst_n = 1'b1;
    tick(1'b0);

    // Idle with en low: no start.
    strobe(3);
    check("idle_no_start", 32'(fs_cnt), 32'd0);

    // Start: first strobe gives frame_start at (0,0) with active high.
    en = 1'b1;
    strobe(1);
    check("start_fs", 32'(fs_cnt), 32'd1);
    check("start_xy", 32'({x, y}), 32'd0);
    check("start_active", 32'(active), 32'd1);

    // One full frame: period and vsync width.
    vs_low = 0;
    strobe(FRAME);
    check("frame_fs_cnt", 32'(fs_cnt), 32'd2);
    check("frame_period", 32'(fs_gap), 32'd120);
    check("vsync_low_strobes", 32'(vs_low), 32'd30);
    check("hsync_fall_x", 32'(hs_fall_x), 32'd10);
    check("hsync_rise_x", 32'(hs_rise_x), 32'd13);

    // Freeze mid-line for 100 clocks.
    strobe(5);
    x_hold    = x;
    y_hold    = y;
    fs_before = fs_cnt;
    for (int i = 0; i < 100; i++) tick(1'b0);
    check("freeze_x", 32'(x), 32'(x_hold));
    check("freeze_y", 32'(y), 32'(y_hold));
    check("freeze_no_fs", 32'(fs_cnt), 32'(fs_before));

    // Drop en at (5,2): drain to the end of the frame, then idle.
    strobe(30);
    check("drain_start_xy", 32'({x, y}), 32'({10'd5, 10'd2}));
    en = 1'b0;
    fs_before = fs_cnt;
    strobe(84);
    check("drain_last_xy", 32'({x, y}), 32'({10'd14, 10'd7}));
    strobe(1);
    check("drain_idle_xy", 32'({x, y}), 32'd0);
    check("drain_idle_active", 32'(active), 32'd0);
    check("drain_no_fs", 32'(fs_cnt), 32'(fs_before));
    strobe(5);
    check("idle_held_xy", 32'({x, y}), 32'd0);

    // Restart, then toggle en within a frame: no interruption.
    en = 1'b1;
    strobe(1);
    check("restart_fs", 32'(fs_cnt), 32'(fs_before + 1));
    strobe(20);
    en = 1'b0;
    strobe(3);
    en = 1'b1;
    strobe(97);
    check("toggle_fs", 32'(fs_cnt), 32'(fs_before + 2));
    check("toggle_period", 32'(fs_gap), 32'd120);

    // Asynchronous reset while hsync is asserted at x=11.
    strobe(11);
    check("pre_rst_hsync", 32'(hsync), 32'd0);
    check("pre_rst_x", 32'(x), 32'd11);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_hsync", 32'(hsync), 32'd1);
    check("async_rst_xy", 32'({x, y}), 32'd0);
    check("async_rst_active", 32'(active), 32'd0);
    tick(1'b1);
    tick(1'b0);
    rst_n = 1'b1;
    fs_before = fs_cnt;
    strobe(1);
    check("post_rst_restart_fs", 32'(fs_cnt), 32'(fs_before + 1));
    strobe(3);

    tick(1'b0);
    tick(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
